// File: rtl/uart_tx_bus_slave_if.sv
// CPU data-memory bus as seen by the UART transmitter: the CPU side drives
// select, direction, address, byte enables and write data; the slave returns read data.
interface uart_tx_bus_slave_if;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (output ce, we, addr, sel, data_i, input data_o);
   modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/uart_tx_bus_slave.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO and a programmable bit period.
// Define UART_TX_IRQ_EN to build the CTRL.irq_en bit and the registered idle interrupt.
module uart_tx_bus_slave #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_bus_slave_if.slave bus,
   output logic               tx,
   output logic               irq
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nx;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [6:0]    count;
   logic          full, empty, busy, ovf;
   logic [15:0]   div, div_m1, per_m1, per_nx, cnt, cnt_nx;
   logic [2:0]    bit_cnt, bit_nx;
   logic [7:0]    shift, shift_nx;
   logic          tx_nx, pop, push, accept, wr_en, irq_en;
   logic [1:0]    reg_sel;
   logic          unused_bits;

   assign wr_en   = bus.ce & bus.we;
   assign reg_sel = bus.addr[3:2];
   assign push    = wr_en && (reg_sel == 2'd0) && bus.sel[0];
   assign full    = (count == 7'(FIFO_DEPTH));
   assign empty   = (count == 7'd0);
   assign accept  = push & ~full;
   assign busy    = (state != IDLE);
   // A divisor of 0 behaves as 1, so the reload value saturates at 0.
   assign div_m1  = (div == 16'd0) ? 16'd0 : div - 16'd1;

   assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.sel[3:2], bus.data_i[31:16]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   count <= count + 7'd1;
            2'b01:   count <= count - 7'd1;
            default: count <= count;
         endcase
         if (push && full)
            ovf <= 1'b1;
         else if (wr_en && (reg_sel == 2'd1) && bus.sel[0] && bus.data_i[3])
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= bus.data_i[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= DEFAULT_DIV;
      end else if (wr_en && (reg_sel == 2'd2)) begin
         if (bus.sel[0]) div[7:0]  <= bus.data_i[7:0];
         if (bus.sel[1]) div[15:8] <= bus.data_i[15:8];
      end
   end

   // Serialiser: tx is registered from the state of the previous cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_nx;
         tx      <= tx_nx;
      end
   end

   always_ff @(posedge clk) begin
      shift  <= shift_nx;
      per_m1 <= per_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      per_nx   = per_m1;
      tx_nx    = 1'b1;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = START;
               shift_nx = mem[rd_ptr];
               per_nx   = div_m1;
               cnt_nx   = div_m1;
            end
         end
         START: begin
            tx_nx = 1'b0;
            if (cnt == 16'd0) begin
               state_nx = DATA;
               cnt_nx   = per_m1;
               bit_nx   = 3'd0;
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         DATA: begin
            tx_nx = shift[0];
            if (cnt == 16'd0) begin
               cnt_nx   = per_m1;
               shift_nx = shift >> 1;
               bit_nx   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = STOP;
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         STOP: begin
            tx_nx = 1'b1;
            if (cnt == 16'd0) begin
               if (!empty) begin
                  pop      = 1'b1;
                  state_nx = START;
                  shift_nx = mem[rd_ptr];
                  per_nx   = div_m1;
                  cnt_nx   = div_m1;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef UART_TX_IRQ_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_en && (reg_sel == 2'd3) && bus.sel[0]) irq_en <= bus.data_i[0];
         irq <= irq_en & empty & ~busy;
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      bus.data_o = 32'd0;
      if (bus.ce && !bus.we) begin
         case (reg_sel)
            2'd1:    bus.data_o = {17'd0, count, 4'd0, ovf, empty, full, busy};
            2'd2:    bus.data_o = {16'd0, div};
            2'd3:    bus.data_o = {31'd0, irq_en};
            default: bus.data_o = 32'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_bus_slave.sv
// Directed bench for uart_tx_bus_slave: register-access vector table plus
// hand-written frame, overflow, divisor, interrupt and reset sequences.
module tb_uart_tx_bus_slave;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx, irq;

`ifdef UART_TX_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   uart_tx_bus_slave_if bus();

   uart_tx_bus_slave #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .tx  (tx),
      .irq (irq)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic tx_log   [8192];
   logic irq_log  [8192];
   logic busy_log [8192];

   // Per-edge capture: index = edge number, value = output 1 time unit after that edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cyc < 8191) cyc++;
         tx_log[cyc]   = tx;
         irq_log[cyc]  = irq;
         busy_log[cyc] = bus.data_o[0];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output int edge_c);
      @(negedge clk);
      bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.sel = s; bus.data_i = d;
      @(posedge clk);
      #2;
      edge_c = cyc;
      bus.ce = 1'b0; bus.we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
      #1;
      d = bus.data_o;
      bus.ce = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Model of one 8N1 frame: tx still high one edge after the pop edge (base+1),
   // then start, 8 data bits LSB first, stop, each p cycles, then 'tail' idle cycles.
   task automatic check_frame(input int base, input int p, input logic [7:0] b,
                              input int tail, input string name);
      int   bad = 0;
      int   first = 0;
      int   idx;
      logic e;
      logic a;
      for (int k = 1; k <= 10 * p + 1 + tail; k++) begin
         if (k == 1) e = 1'b1;
         else if (k <= 10 * p + 1) begin
            idx = (k - 2) / p;
            if (idx == 0)      e = 1'b0;
            else if (idx == 9) e = 1'b1;
            else               e = b[idx-1];
         end else e = 1'b1;
         a = tx_log[base + k];
         if (a !== e) begin
            if (bad == 0) first = k;
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL %s: %0d wrong tx cycles, first at offset %0d, got %b expected %b",
                  name, bad, first, tx_log[base + first], !tx_log[base + first]);
      end
   endtask

   logic [31:0] r;
   int          n, e_c, c0, ones, bad_idle;

   initial begin
      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;

      tbl[0]  = '{1'b0, 32'h4, 4'h0, 32'h0,        32'h0000_0004, "rst_status"};
      tbl[1]  = '{1'b0, 32'h8, 4'h0, 32'h0,        32'h0000_01B2, "rst_divisor"};
      tbl[2]  = '{1'b0, 32'h0, 4'h0, 32'h0,        32'h0,         "txdata_reads_zero"};
      tbl[3]  = '{1'b0, 32'hC, 4'h0, 32'h0,        32'h0,         "rst_ctrl"};
      tbl[4]  = '{1'b1, 32'h4, 4'h0, 32'h0,        32'h0,         "rdata_zero_on_write"};
      tbl[5]  = '{1'b1, 32'h8, 4'h1, 32'h0000_1234, 32'h0,        "div_wr_lo"};
      tbl[6]  = '{1'b0, 32'h8, 4'h0, 32'h0,        32'h0000_0134, "div_lo_byte"};
      tbl[7]  = '{1'b1, 32'h8, 4'h2, 32'h0000_AB00, 32'h0,        "div_wr_hi"};
      tbl[8]  = '{1'b0, 32'h8, 4'h0, 32'h0,        32'h0000_AB34, "div_hi_byte"};
      tbl[9]  = '{1'b1, 32'h8, 4'h0, 32'h0000_FFFF, 32'h0,        "div_wr_nosel"};
      tbl[10] = '{1'b0, 32'h8, 4'h0, 32'h0,        32'h0000_AB34, "div_nosel_kept"};
      tbl[11] = '{1'b1, 32'h8, 4'hF, 32'hFFFF_0004, 32'h0,        "div_wr_4"};
      tbl[12] = '{1'b0, 32'h8, 4'h0, 32'h0,        32'h0000_0004, "div_is_4"};
      tbl[13] = '{1'b1, 32'hC, 4'h1, 32'h1,        32'h0,         "ctrl_wr_1"};
      tbl[14] = '{1'b0, 32'hC, 4'h0, 32'h0,        {31'd0, IRQ_ON}, "ctrl_rd_1"};
      tbl[15] = '{1'b1, 32'hC, 4'h1, 32'h0,        32'h0,         "ctrl_wr_0"};
      tbl[16] = '{1'b0, 32'hC, 4'h0, 32'h0,        32'h0,         "ctrl_rd_0"};
      tbl[17] = '{1'b1, 32'h0, 4'h2, 32'h0000_0077, 32'h0,        "txdata_wr_nosel0"};
      tbl[18] = '{1'b0, 32'h4, 4'h0, 32'h0,        32'h0000_0004, "no_push_without_sel0"};

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'h1);
      check("rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 19; i++) begin
         if (tbl[i].wr) begin
            @(negedge clk);
            bus.ce = 1'b1; bus.we = 1'b1; bus.addr = tbl[i].a;
            bus.sel = tbl[i].s; bus.data_i = tbl[i].d;
            #1;
            check(tbl[i].name, bus.data_o, tbl[i].exp);
            @(posedge clk);
            #2;
            bus.ce = 1'b0; bus.we = 1'b0;
         end else begin
            rd(tbl[i].a, r);
            check(tbl[i].name, r, tbl[i].exp);
         end
      end

      // Single frame 0x55 at P=4 while STATUS is held on the bus to watch busy.
      wr(32'h0, 4'h1, 32'h55, n);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h4;
      wait_to(n + 46);
      bus.ce = 1'b0;
      check_frame(n, 4, 8'h55, 3, "frame_55_p4");
      ones = 0;
      for (int k = 1; k <= 45; k++) if (busy_log[n + k] === 1'b1) ones++;
      check("busy_cycles", 32'(ones), 32'd40);
      check("busy_first", 32'(busy_log[n + 1]), 32'h1);
      check("busy_last", 32'(busy_log[n + 40]), 32'h1);

      // Fill the FIFO at P=2, overflow it, then drain back-to-back.
      wr(32'h8, 4'h3, 32'h2, e_c);
      for (int i = 1; i <= 9; i++) begin
         wr(32'h0, 4'h1, 32'(i), e_c);
         if (i == 1) n = e_c;
      end
      rd(32'h4, r);
      check("status_full", r, 32'h0000_0803);
      wr(32'h0, 4'h1, 32'h0A, e_c);
      rd(32'h4, r);
      check("status_ovf", r, 32'h0000_080B);
      @(negedge clk);
      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h4;
      #1;
      check("rdata_zero_no_ce", bus.data_o, 32'h0);
      wr(32'h4, 4'h1, 32'h8, e_c);
      rd(32'h4, r);
      check("ovf_cleared", r, 32'h0000_0803);
      wait_to(n + 20 * 9 + 4);
      for (int f = 0; f < 9; f++)
         check_frame(n + 20 * f, 2, 8'(f + 1), (f == 8) ? 2 : 0, $sformatf("b2b_frame_%0d", f + 1));
      rd(32'h4, r);
      check("drained_status", r, 32'h0000_0004);

      // Divisor change mid-frame applies only from the next frame.
      wr(32'h0, 4'h1, 32'h3C, n);
      wr(32'h0, 4'h1, 32'hC5, e_c);
      wr(32'h8, 4'h3, 32'h8, e_c);
      wait_to(n + 20 + 81 + 3);
      check_frame(n, 2, 8'h3C, 0, "div_old_frame");
      check_frame(n + 20, 8, 8'hC5, 2, "div_new_frame");

      wr(32'h8, 4'h3, 32'h0, e_c);
      wr(32'h0, 4'h1, 32'hA3, n);
      wait_to(n + 15);
      check_frame(n, 1, 8'hA3, 3, "div0_frame");

      // Interrupt: enable while idle, then one P=1 frame.
      wr(32'hC, 4'h1, 32'h1, c0);
      wait_to(c0 + 3);
      check("irq_pre_enable", 32'(irq_log[c0]), 32'h0);
      check("irq_idle", 32'(irq_log[c0 + 1]), 32'(IRQ_ON));
      wr(32'h0, 4'h1, 32'h81, n);
      wait_to(n + 14);
      check("irq_at_write", 32'(irq_log[n]), 32'(IRQ_ON));
      check("irq_drop", 32'(irq_log[n + 1]), 32'h0);
      check("irq_low_at_stop_end", 32'(irq_log[n + 11]), 32'h0);
      check("irq_rise", 32'(irq_log[n + 12]), 32'(IRQ_ON));
      wr(32'hC, 4'h1, 32'h0, e_c);

      // Reset in the middle of the data bits with three bytes queued.
      wr(32'h8, 4'h3, 32'h4, e_c);
      wr(32'h0, 4'h1, 32'h00, n);
      for (int i = 0; i < 3; i++) wr(32'h0, 4'h1, 32'h00, e_c);
      wait_to(n + 12);
      @(negedge clk);
      check("pre_rst_tx_low", 32'(tx), 32'h0);
      rst = 1'b0;
      #1;
      check("rst_tx_immediate", 32'(tx), 32'h1);
      rd(32'h4, r);
      check("status_in_rst", r, 32'h0000_0004);
      @(negedge clk);
      rst = 1'b1;
      rd(32'h4, r);
      check("status_after_rst", r, 32'h0000_0004);
      rd(32'h8, r);
      check("div_after_rst", r, 32'h0000_01B2);
      c0 = cyc;
      wait_to(c0 + 60);
      bad_idle = 0;
      for (int k = 1; k <= 60; k++) if (tx_log[c0 + k] !== 1'b1) bad_idle++;
      check("no_frames_after_rst", 32'(bad_idle), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
